// File: rtl/smac_seq_ctrl_if.sv
// Job/result/MAC-control bundle for smac_seq_ctrl.
// Optional i_len field is present only when SMAC_VARLEN_EN is defined.
interface smac_seq_ctrl_if #(
   parameter int CWIDTH = 8
);
   logic              i_valid;
   logic              o_ready;
`ifdef SMAC_VARLEN_EN
   logic [3:0]        i_len;
`endif
   logic              o_mac_rst_n;
   logic              o_loadA;
   logic              o_loadB;
   logic              i_bit;
   logic [CWIDTH:0]   o_sum;
   logic              o_valid;
   logic              i_ready;
   logic              o_busy;

`ifdef SMAC_VARLEN_EN
   modport slave (
      input  i_valid, i_len, i_bit, i_ready,
      output o_ready, o_mac_rst_n, o_loadA, o_loadB, o_sum, o_valid, o_busy
   );
   modport master (
      output i_valid, i_len, i_bit, i_ready,
      input  o_ready, o_mac_rst_n, o_loadA, o_loadB, o_sum, o_valid, o_busy
   );
`else
   modport slave (
      input  i_valid, i_bit, i_ready,
      output o_ready, o_mac_rst_n, o_loadA, o_loadB, o_sum, o_valid, o_busy
   );
   modport master (
      output i_valid, i_bit, i_ready,
      input  o_ready, o_mac_rst_n, o_loadA, o_loadB, o_sum, o_valid, o_busy
   );
`endif
endinterface

// File: rtl/smac_seq_ctrl.sv
// Job sequencer for the 16-input scaled stochastic MAC: releases the MAC
// from reset, pulses the operand load strobes, counts 1s on the MAC output
// over a fixed window (after discarding PIPE latency bits) and returns the
// count over a valid/ready handshake.
// Optional macro SMAC_VARLEN_EN: per-job window 2^i_len (clamped to CWIDTH),
// result scaled back to full-scale N.
//
// state | meaning
// IDLE  | waiting for a job, MAC held in reset
// LOAD  | one cycle, MAC released and operand strobes pulsed
// RUN   | MAC streaming, window bits accumulated
// DONE  | result presented until accepted
module smac_seq_ctrl #(
   parameter int CWIDTH = 8,
   parameter int PIPE   = 2
) (
   input  logic         clk,
   input  logic         rst,
   smac_seq_ctrl_if.slave bus
);
   localparam int N     = 1 << CWIDTH;
   localparam int CNT_W = $clog2(PIPE + N + 1);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [CWIDTH:0]  acc_q, acc_d;
   logic [CNT_W-1:0] win_load;
   logic [CNT_W-1:0] win_cur;
   logic [CWIDTH:0]  sum_out;

`ifdef SMAC_VARLEN_EN
   logic [3:0] len_q, len_d, len_c;

   assign len_c    = (int'(bus.i_len) > CWIDTH) ? 4'(CWIDTH) : bus.i_len;
   assign win_load = CNT_W'(1) << len_c;
   assign win_cur  = CNT_W'(1) << len_q;
   assign sum_out  = acc_d << (4'(CWIDTH) - len_q);
`else
   assign win_load = CNT_W'(N);
   assign win_cur  = CNT_W'(N);
   assign sum_out  = acc_d;
`endif

   // Next-state, remaining-cycle down-counter and accumulator update.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      acc_d   = acc_q;
`ifdef SMAC_VARLEN_EN
      len_d   = len_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.i_valid) begin
               state_d = LOAD;
               acc_d   = '0;
               // rem counts down to 0 on the last window cycle; the window
               // is the final win_cur cycles of the run.
               rem_d   = CNT_W'(PIPE) + win_load - CNT_W'(1);
`ifdef SMAC_VARLEN_EN
               len_d   = len_c;
`endif
            end
         end
         LOAD: state_d = RUN;
         RUN: begin
            if ((rem_q < win_cur) && bus.i_bit && (acc_q != (CWIDTH+1)'(N)))
               acc_d = acc_q + 1'b1;
            if (rem_q == '0)
               state_d = DONE;
            else
               rem_d = rem_q - 1'b1;
         end
         DONE: begin
            if (bus.i_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counters and registered outputs decoded from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         rem_q           <= '0;
         acc_q           <= '0;
`ifdef SMAC_VARLEN_EN
         len_q           <= 4'(CWIDTH);
`endif
         bus.o_ready     <= 1'b1;
         bus.o_mac_rst_n <= 1'b0;
         bus.o_loadA     <= 1'b0;
         bus.o_loadB     <= 1'b0;
         bus.o_sum       <= '0;
         bus.o_valid     <= 1'b0;
         bus.o_busy      <= 1'b0;
      end else begin
         state_q         <= state_d;
         rem_q           <= rem_d;
         acc_q           <= acc_d;
`ifdef SMAC_VARLEN_EN
         len_q           <= len_d;
`endif
         bus.o_ready     <= (state_d == IDLE);
         bus.o_mac_rst_n <= (state_d != IDLE);
         bus.o_loadA     <= (state_d == LOAD);
         bus.o_loadB     <= (state_d == LOAD);
         bus.o_valid     <= (state_d == DONE);
         bus.o_busy      <= (state_d != IDLE);
         if ((state_q == RUN) && (state_d == DONE))
            bus.o_sum <= sum_out;
      end
   end
endmodule
